// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        Idle,
        Run,
        Sign
    } mul_state_t;

    localparam int unsigned MinWidth = 2;

    // Width of a step counter that must reach w-1.
    function automatic int unsigned cnt_width(int unsigned w);
        return (w > MinWidth) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_neg.sv
// Combinational conditional two's-complement negator.
module mul_neg #(
    parameter int unsigned N = 32
) (
    input  logic         en,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    always_comb begin
        out = en ? ((~in) + N'(1)) : in;
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier for MULT/MULTU: WIDTH steps on magnitudes, then sign fix.
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               load,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicador,
    input  logic [WIDTH-1:0]   multiplicando,
    output logic [2*WIDTH-1:0] resultado,
    output logic               busy,
    output logic               done
);

    import mul_pkg::*;

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;

    mul_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    res_q, res_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_a, abs_b, addend;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    fixed_acc;

    mul_neg #(.N(WIDTH)) u_abs_a (
        .en  (is_signed & multiplicador[WIDTH-1]),
        .in  (multiplicador),
        .out (abs_a)
    );

    mul_neg #(.N(WIDTH)) u_abs_b (
        .en  (is_signed & multiplicando[WIDTH-1]),
        .in  (multiplicando),
        .out (abs_b)
    );

    mul_neg #(.N(PW)) u_fix (
        .en  (neg_q),
        .in  (acc_q),
        .out (fixed_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        res_d    = res_q;
        done_d   = 1'b0;
        addend   = mplier_q[0] ? mcand_q : '0;
        // Carry out of the upper-half add becomes the new msb after the shift.
        sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};

        case (state_q)
            Idle: begin
                if (load) begin
                    mplier_d = abs_a;
                    mcand_d  = abs_b;
                    neg_d    = is_signed & (multiplicador[WIDTH-1] ^ multiplicando[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = Run;
                end
            end
            Run: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = Sign;
                end
            end
            Sign: begin
                res_d   = fixed_acc;
                done_d  = 1'b1;
                state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q  <= Idle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    assign resultado = res_q;
    assign done      = done_q;
    assign busy      = (state_q != Idle);

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential shift-add multiplier serving the MIPS datapath's MULT/MULTU instructions. Accepts two WIDTH-bit operands on a `load` strobe and computes the 2·WIDTH-bit product over a fixed number of cycles. Supports signed and unsigned modes and reports progress through a `busy`/`done` handshake so the control unit can stall until HI/LO are valid. Its outputs feed the HI/LO register pair.

## Interface
- `WIDTH`, default 32: operand width, ≥ 2; product width is 2·WIDTH.
- `Clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces idle state and clears outputs.
- `load`  in  1  start strobe; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with `load`.
- `multiplicador`  in  WIDTH  multiplier operand; sampled with `load`.
- `multiplicando`  in  WIDTH  multiplicand operand; sampled with `load`.
- `resultado`  out  2·WIDTH  product; upper half maps to HI, lower half to LO; held until the next completion.
- `busy`  out  1  high while an operation is in flight (RUN or SIGN).
- `done`  out  1  one-cycle pulse when `resultado` is updated.

## Operation
- States: IDLE, RUN, SIGN.
- IDLE: if `load`=1, latch |operands| (absolute value when `is_signed`=1; raw otherwise), latch sign flag = `is_signed` & (msb_a ^ msb_b), clear accumulator and counter, go to RUN. Otherwise stay.
- RUN: one shift-add step per cycle on the unsigned magnitudes: if multiplier lsb is 1, add multiplicand into the upper half of a 2·WIDTH+1 accumulator; then shift {carry, accumulator} right by 1. Counter increments 0..WIDTH-1; at WIDTH-1 go to SIGN.
- SIGN: `resultado` <= sign flag ? two's-complement negation of accumulator : accumulator; `done` <= 1; go to IDLE.
- Magnitude of the most negative value (e.g. 0x8000_0000) is treated as unsigned 2^(WIDTH-1); no overflow handling is needed.
- Latency is fixed regardless of operand values (zero operands do not shortcut).
- `load` while busy: ignored, in-flight operation unaffected, no queuing.
- `load` in the cycle `done` is high: accepted (state is already IDLE).

## Timing
- Reset values: `resultado`=0, `done`=0, `busy`=0, state=IDLE, counter=0.
- `load` sampled at edge E0 → `busy` high from E0 to E(WIDTH+1); `done` high for exactly one cycle after edge E(WIDTH+1); `resultado` valid from the same edge.
- Throughput: one product per WIDTH+1 cycles with back-to-back `load`.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared, partial result discarded; no `done`.
- `resultado` changes only on the SIGN edge or on reset.

## Structure
- Package `mul_pkg`: state enum `mul_state_t` {IDLE, RUN, SIGN}; localparam helper for counter width ($clog2(WIDTH)).
- One sub-module is natural: `mul_neg`, a combinational parametrised conditional two's-complement negator (`en`, `in`, `out`, width N), reused for input absolute value (WIDTH) and output sign fix (2·WIDTH).

## Test plan
- Unsigned: `is_signed`=0, 3 × 5 → after 33 cycles `done` pulse, `resultado`=64'h0000_0000_0000_000F.
- Signed: `is_signed`=1, 0xFFFF_FFFD (−3) × 5 → `resultado`=64'hFFFF_FFFF_FFFF_FFF1.
- Extremes: unsigned 0xFFFF_FFFF × 0xFFFF_FFFF → 64'hFFFF_FFFE_0000_0001; signed 0x8000_0000 × 0x8000_0000 → 64'h4000_0000_0000_0000.
- Busy protection: load 7×9, pulse `load` with 2×2 at cycle 10 → single `done` with 63 (0x3F); `busy` continuous for 33 cycles.
- Reset mid-operation: load 6×7, assert `reset` at cycle 15 → `busy`=0, `resultado`=0, no `done`; following load 6×7 yields 42 (0x2A).
- Back-to-back: assert `load` 4×4 during the `done` cycle of a prior op → second `done` exactly 33 cycles later, `resultado`=16 (0x10); repeat with WIDTH=8 (−2×3 signed → 16'hFFFA, 9 cycles).
